// File: rtl/fpu_pkg.sv
// fpu_pkg: opcodes, flag bit positions and issue FSM states shared by the FPU front-end
package fpu_pkg;
  localparam int FLAG_W_DEF = 8;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd2;
  localparam logic [2:0] OP_SQRT = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam int FL_UNOV = 0;
  localparam int FL_INV = 1;
  localparam int FL_INEXACT = 2;
  localparam int FL_DIVZ = 3;
  localparam int FL_LESS = 4;
  localparam int FL_EQ = 5;
  localparam int FL_GREAT = 6;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/fpu_op_fifo.sv
// fpu_op_fifo: synchronous request FIFO, pointers carry an extra wrap bit to tell full from empty
module fpu_op_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstp,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign level = wp - rp;
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (rstp) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queued issue/retire front-end for the single-precision FPU units,
// one op in flight, watchdog-guarded, tagged valid/ready response.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int NUM_OPS = 5,
  parameter int FLAG_W = FLAG_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        rstp,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [2:0]                  req_op,
  input  logic [2:0]                  req_rnd,
  input  logic [WIDTH-1:0]            req_a,
  input  logic [WIDTH-1:0]            req_b,
  input  logic [TAG_W-1:0]            req_tag,
  output logic [NUM_OPS-1:0]          u_start,
  output logic [WIDTH-1:0]            u_in1,
  output logic [WIDTH-1:0]            u_in2,
  output logic [2:0]                  u_rnd,
  input  logic [NUM_OPS-1:0]          u_done,
  input  logic [NUM_OPS*WIDTH-1:0]    u_out,
  input  logic [NUM_OPS*FLAG_W-1:0]   u_flags,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [WIDTH-1:0]            rsp_data,
  output logic [FLAG_W-1:0]           rsp_flags,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic                        rsp_timeout,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      fifo_level
);
  localparam int DW = 6 + 2 * WIDTH + TAG_W;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [FLAG_W-1:0] INV_ONLY = FLAG_W'(1) << FL_INV;
  state_t state, state_nx;
  logic empty, full, pop, legal, done_sel, expire;
  logic [2:0] h_op, h_rnd, op;
  logic [WIDTH-1:0] h_a, h_b;
  logic [TAG_W-1:0] h_tag, tag_r;
  logic [CW-1:0] wd;
  logic [NUM_OPS-1:0] sel;
  fpu_op_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rstp(rstp),
    .push(req_valid && req_ready),
    .pop(pop),
    .din({req_op, req_rnd, req_a, req_b, req_tag}),
    .dout({h_op, h_rnd, h_a, h_b, h_tag}),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign req_ready = !full;
  assign legal = h_op < 3'(NUM_OPS);
  assign sel = NUM_OPS'(1) << op;
  // only the selected unit's done counts; strays from idle units are masked
  assign done_sel = |(u_done & sel);
  assign expire = wd == CW'(TIMEOUT - 1);
  assign u_start = (state == S_ISSUE) ? sel : '0;
  assign rsp_valid = state == S_RESP;
  assign busy = (state != S_IDLE) || !empty;
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      S_IDLE: begin
        pop = !empty;
        state_nx = empty ? S_IDLE : legal ? S_ISSUE : S_RESP;
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: state_nx = (done_sel || expire) ? S_RESP : S_WAIT;
      S_RESP: state_nx = rsp_ready ? S_IDLE : S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rstp) state <= S_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rstp) begin
      op <= '0;
      u_rnd <= '0;
      u_in1 <= '0;
      u_in2 <= '0;
      tag_r <= '0;
      wd <= '0;
      rsp_data <= '0;
      rsp_flags <= '0;
      rsp_tag <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (pop) begin
        op <= h_op;
        u_rnd <= h_rnd;
        u_in1 <= h_a;
        u_in2 <= h_b;
        tag_r <= h_tag;
      end
      if (state == S_ISSUE) wd <= '0;
      else if (state == S_WAIT) wd <= wd + CW'(1);
      if (pop && !legal) begin
        rsp_data <= '0;
        rsp_flags <= INV_ONLY;
        rsp_tag <= h_tag;
        rsp_timeout <= 1'b0;
      end
      // done beats a same-cycle watchdog expiry
      if (state == S_WAIT && done_sel) begin
        rsp_data <= (op == OP_CMP) ? '0 : u_out[op*WIDTH +: WIDTH];
        rsp_flags <= u_flags[op*FLAG_W +: FLAG_W];
        rsp_tag <= tag_r;
        rsp_timeout <= 1'b0;
      end else if (state == S_WAIT && expire) begin
        rsp_data <= '0;
        rsp_flags <= INV_ONLY;
        rsp_tag <= tag_r;
        rsp_timeout <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl with latency-programmable stub units
module tb_fpu_issue_ctrl;
  logic clk = 1'b0;
  logic rstp, req_valid, rsp_ready;
  logic req_ready, rsp_valid, rsp_timeout, busy;
  logic [2:0] req_op, req_rnd, u_rnd;
  logic [31:0] req_a, req_b, u_in1, u_in2, rsp_data;
  logic [3:0] req_tag, rsp_tag;
  logic [4:0] u_start, u_done, stray;
  logic [4:0] done_q = '0;
  logic [159:0] u_out;
  logic [39:0] u_flags;
  logic [7:0] rsp_flags;
  logic [2:0] fifo_level;
  int lat[5] = '{default: 0};
  int cnt[5] = '{default: 0};
  logic [31:0] res[5];
  logic [7:0] flg[5];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fpu_issue_ctrl #(.WIDTH(32), .DEPTH(4), .TAG_W(4), .NUM_OPS(5), .FLAG_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rstp(rstp), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rnd(req_rnd), .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .u_start(u_start),
    .u_in1(u_in1), .u_in2(u_in2), .u_rnd(u_rnd), .u_done(u_done), .u_out(u_out), .u_flags(u_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout), .busy(busy), .fifo_level(fifo_level)
  );
  // stub units: done pulses lat cycles after start; lat 0 never finishes; reset does not touch them
  always @(posedge clk)
    for (int k = 0; k < 5; k++) begin
      done_q[k] <= 1'b0;
      if (u_start[k] && lat[k] > 0) cnt[k] <= lat[k];
      else if (cnt[k] > 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) done_q[k] <= 1'b1;
      end
    end
  assign u_done = done_q | stray;
  always_comb begin
    u_out = '0;
    u_flags = '0;
    for (int k = 0; k < 5; k++) begin
      u_out[k*32 +: 32] = res[k];
      u_flags[k*8 +: 8] = flg[k];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag, input logic [2:0] rnd);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag; req_rnd = rnd;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_rsp(input string tag, output int n, output logic [4:0] starts);
    n = 0; starts = '0;
    while (!rsp_valid && n < 100) begin
      starts |= u_start;
      @(negedge clk);
      n++;
    end
    check({tag, "_rv"}, rsp_valid, 1);
  endtask
  task automatic wait_start(input int k);
    int n = 0;
    while (!u_start[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("start_seen", u_start[k], 1);
  endtask
  initial begin
    int n, acc;
    logic rdy, anyv;
    logic [4:0] st, anys;
    rstp = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1; stray = '0;
    req_op = '0; req_rnd = '0; req_a = '0; req_b = '0; req_tag = '0;
    for (int k = 0; k < 5; k++) begin res[k] = '0; flg[k] = '0; end
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_start", u_start, 0);
    check("rst_data", rsp_data, 0);
    rstp = 1'b0;
    @(negedge clk);
    // single add: latency and payload
    lat[0] = 3; res[0] = 32'h40400000; flg[0] = 8'h00;
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'h3F800000; req_b = 32'h40000000; req_tag = 4'd3; req_rnd = 3'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check("add_level_n1", fifo_level, 1);
    check("add_start_n1", u_start, 0);
    @(negedge clk);
    check("add_start_n2", u_start, 5'b00001);
    check("add_in1", u_in1, 32'h3F800000);
    check("add_in2", u_in2, 32'h40000000);
    check("add_rnd", u_rnd, 3'd1);
    @(negedge clk);
    check("add_start_n3", u_start, 0);
    n = 0;
    while (!u_done[0] && n < 50) begin @(negedge clk); n++; end
    check("add_done_seen", u_done[0], 1);
    check("add_rv_at_done", rsp_valid, 0);
    @(negedge clk);
    check("add_rv_done1", rsp_valid, 1);
    check("add_data", rsp_data, 32'h40400000);
    check("add_tag", rsp_tag, 3);
    check("add_timeout", rsp_timeout, 0);
    @(negedge clk);
    check("add_rv_drop", rsp_valid, 0);
    // backpressure: fill FIFO behind a stalled response
    lat[0] = 2; rsp_ready = 1'b0; acc = 0;
    req_valid = 1'b1; req_op = 3'd0; req_rnd = 3'd0;
    for (int i = 0; i < 10; i++) begin
      req_tag = 4'(acc);
      rdy = req_ready;
      @(negedge clk);
      if (rdy) acc++;
    end
    req_valid = 1'b0;
    check("bp_accepted", acc, 5);
    check("bp_ready", req_ready, 0);
    check("bp_level", fifo_level, 4);
    check("bp_busy", busy, 1);
    rsp_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      wait_rsp("bp", n, st);
      check("bp_tag", rsp_tag, 64'(j));
      check("bp_data", rsp_data, 32'h40400000);
      @(negedge clk);
    end
    check("bp_level_empty", fifo_level, 0);
    // div that never completes hits the watchdog
    lat[2] = 0;
    push(3'd2, 32'h3F800000, 32'h00000000, 4'd5, 3'd0);
    wait_start(2);
    n = 0;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("to_cycles", n, 17);
    check("to_flag", rsp_timeout, 1);
    check("to_data", rsp_data, 0);
    check("to_flags", rsp_flags, 8'h02);
    check("to_tag", rsp_tag, 5);
    @(negedge clk);
    // illegal opcode followed by a normal add
    res[0] = 32'h40A00000; flg[0] = 8'h04;
    push(3'd7, 32'h1, 32'h2, 4'd6, 3'd0);
    push(3'd0, 32'h40000000, 32'h40400000, 4'd7, 3'd0);
    wait_rsp("ill", n, st);
    check("ill_nostart", st, 0);
    check("ill_tag", rsp_tag, 6);
    check("ill_data", rsp_data, 0);
    check("ill_flags", rsp_flags, 8'h02);
    check("ill_timeout", rsp_timeout, 0);
    @(negedge clk);
    wait_rsp("ill_next", n, st);
    check("next_start", st, 5'b00001);
    check("next_tag", rsp_tag, 7);
    check("next_data", rsp_data, 32'h40A00000);
    check("next_flags", rsp_flags, 8'h04);
    @(negedge clk);
    // compare with a stray done from the mul unit
    lat[4] = 2; res[4] = 32'h12345678; flg[4] = 8'h40;
    res[1] = 32'hDEADBEEF; flg[1] = 8'h02; stray = 5'b00010;
    push(3'd4, 32'h40000000, 32'h3F800000, 4'd9, 3'd2);
    wait_start(4);
    @(negedge clk);
    check("cmp_in1_hold", u_in1, 32'h40000000);
    check("cmp_rnd_hold", u_rnd, 3'd2);
    wait_rsp("cmp", n, st);
    check("cmp_data", rsp_data, 0);
    check("cmp_flags", rsp_flags, 8'h40);
    check("cmp_tag", rsp_tag, 9);
    @(negedge clk);
    stray = '0;
    // reset in WAIT with two requests queued
    lat[3] = 6;
    push(3'd3, 32'h40800000, 32'h0, 4'd8, 3'd0);
    push(3'd3, 32'h41100000, 32'h0, 4'd9, 3'd0);
    push(3'd3, 32'h41800000, 32'h0, 4'd10, 3'd0);
    check("mid_level", fifo_level, 2);
    check("mid_busy", busy, 1);
    rstp = 1'b1;
    @(negedge clk);
    rstp = 1'b0;
    check("mid_rv", rsp_valid, 0);
    check("mid_level0", fifo_level, 0);
    check("mid_busy0", busy, 0);
    anyv = 1'b0; anys = '0;
    for (int i = 0; i < 12; i++) begin
      anyv |= rsp_valid;
      anys |= u_start;
      @(negedge clk);
    end
    check("late_rv", anyv, 0);
    check("late_start", anys, 0);
    check("late_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
